// File: rtl/dram_ctrl_pkg.sv
// Shared types and default timing for the FPM DRAM controller.
package dram_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRow,
    StCol,
    StHold,
    StPrecharge,
    StRefCas,
    StRefRas,
    StRefEnd
  } state_e;

  localparam int unsigned DefRowBits         = 11;
  localparam int unsigned DefColBits         = 11;
  localparam int unsigned DefRefreshInterval = 600;  // 15 us at 40 MHz
  localparam int unsigned DefTRcd            = 2;
  localparam int unsigned DefTRp             = 3;
  localparam int unsigned DefTRfsh           = 4;

  // Wide enough for the longest per-state hold (T_RCD, T_RP, T_RFSH)
  localparam int unsigned PhaseCntW = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dram_controller_if.sv
// CPU-side strobes/address in, DRAM control and DTACK out.
interface dram_controller_if import dram_ctrl_pkg::*; #(
  parameter int unsigned ROW_BITS = DefRowBits,
  parameter int unsigned COL_BITS = DefColBits
) ();

  localparam int unsigned MaW   = max_u(ROW_BITS, COL_BITS);
  localparam int unsigned AddrW = ROW_BITS + COL_BITS;

  logic             i_dram;   // active-low select
  logic             i_as;     // active-low
  logic             i_uds;    // active-low
  logic             i_lds;    // active-low
  logic             i_rw;     // 1 = read
  logic [AddrW-1:0] i_addr;   // CPU A[22:1]
  logic [MaW-1:0]   o_ma;
  logic             o_ras;
  logic             o_casl;
  logic             o_casu;
  logic             o_we;
  logic             o_dtack_dram;
  logic             o_refresh_busy;

  modport slave (
    input  i_dram, i_as, i_uds, i_lds, i_rw, i_addr,
    output o_ma, o_ras, o_casl, o_casu, o_we, o_dtack_dram, o_refresh_busy
  );

  modport master (
    output i_dram, i_as, i_uds, i_lds, i_rw, i_addr,
    input  o_ma, o_ras, o_casl, o_casu, o_we, o_dtack_dram, o_refresh_busy
  );

endinterface

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter with a single-entry pending flag.
module dram_refresh_timer import dram_ctrl_pkg::*; #(
  parameter int unsigned REFRESH_INTERVAL = DefRefreshInterval
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ack,
  output logic o_req
);

  localparam int unsigned CntW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  logic [CntW-1:0] r_cnt;
  logic            r_pending;
  logic            w_wrap;

  assign w_wrap = (r_cnt == CntW'(REFRESH_INTERVAL - 1));
  // The wrap cycle itself already requests, so a same-cycle CPU access loses the tie
  assign o_req  = r_pending | w_wrap;

  // Counter wraps at the interval; pending is a flag, extra wraps are dropped
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + CntW'(1);
      if (i_ack)       r_pending <= 1'b0;
      else if (w_wrap) r_pending <= 1'b1;
    end
  end

endmodule

// File: rtl/dram_controller.sv
// FPM DRAM sequencer: RAS/CAS/WE/MA generation, DTACK, CBR refresh arbitration.
module dram_controller import dram_ctrl_pkg::*; #(
  parameter int unsigned ROW_BITS         = DefRowBits,
  parameter int unsigned COL_BITS         = DefColBits,
  parameter int unsigned REFRESH_INTERVAL = DefRefreshInterval,
  parameter int unsigned T_RCD            = DefTRcd,
  parameter int unsigned T_RP             = DefTRp,
  parameter int unsigned T_RFSH           = DefTRfsh
) (
  input logic              i_clk,
  input logic              i_rst,
  dram_controller_if.slave bus
);

  localparam int unsigned MaW   = max_u(ROW_BITS, COL_BITS);
  localparam int unsigned AddrW = ROW_BITS + COL_BITS;

  logic [1:0] r_as_sync, r_uds_sync, r_lds_sync, r_dram_sync;
  logic       w_as, w_uds, w_lds, w_dram;

  state_e                r_state, w_state_d;
  logic [PhaseCntW-1:0]  r_cnt, w_cnt_d;
  logic [COL_BITS-1:0]   r_col, w_col_d;
  logic                  r_rw, w_rw_d;
  logic                  r_lane_u, w_lane_u_d;
  logic                  r_lane_l, w_lane_l_d;
  logic [MaW-1:0]        r_ma, w_ma_d;
  logic                  r_ras, w_ras_d;
  logic                  r_casl, w_casl_d;
  logic                  r_casu, w_casu_d;
  logic                  r_we, w_we_d;
  logic                  r_dtack, w_dtack_d;
  logic                  r_busy, w_busy_d;
  logic                  w_ref_req, w_ref_ack;

  // Two-flop synchronisers for the asynchronous strobes; idle level is high
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_as_sync   <= 2'b11;
      r_uds_sync  <= 2'b11;
      r_lds_sync  <= 2'b11;
      r_dram_sync <= 2'b11;
    end else begin
      r_as_sync   <= {r_as_sync[0], bus.i_as};
      r_uds_sync  <= {r_uds_sync[0], bus.i_uds};
      r_lds_sync  <= {r_lds_sync[0], bus.i_lds};
      r_dram_sync <= {r_dram_sync[0], bus.i_dram};
    end
  end

  assign w_as   = r_as_sync[1];
  assign w_uds  = r_uds_sync[1];
  assign w_lds  = r_lds_sync[1];
  assign w_dram = r_dram_sync[1];

  dram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_ack(w_ref_ack),
    .o_req(w_ref_req)
  );

  // State, latched cycle info and registered (glitch-free) DRAM outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_col    <= '0;
      r_rw     <= 1'b1;
      r_lane_u <= 1'b0;
      r_lane_l <= 1'b0;
      r_ma     <= '0;
      r_ras    <= 1'b1;
      r_casl   <= 1'b1;
      r_casu   <= 1'b1;
      r_we     <= 1'b1;
      r_dtack  <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_col    <= w_col_d;
      r_rw     <= w_rw_d;
      r_lane_u <= w_lane_u_d;
      r_lane_l <= w_lane_l_d;
      r_ma     <= w_ma_d;
      r_ras    <= w_ras_d;
      r_casl   <= w_casl_d;
      r_casu   <= w_casu_d;
      r_we     <= w_we_d;
      r_dtack  <= w_dtack_d;
      r_busy   <= w_busy_d;
    end
  end

  // Next state, then outputs decoded from the next state so they register with it
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt + PhaseCntW'(1);
    w_col_d    = r_col;
    w_rw_d     = r_rw;
    w_lane_u_d = r_lane_u;
    w_lane_l_d = r_lane_l;
    w_ma_d     = r_ma;
    w_ref_ack  = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        if (w_ref_req) begin
          w_ref_ack = 1'b1;
          w_state_d = StRefCas;
        end else if (!w_as && !w_dram) begin
          w_state_d = StRow;
          w_col_d   = bus.i_addr[COL_BITS-1:0];
          w_rw_d    = bus.i_rw;
          w_ma_d    = MaW'(bus.i_addr[AddrW-1:COL_BITS]);
        end
      end
      StRow: begin
        if (w_as) begin
          w_state_d = StPrecharge;
          w_cnt_d   = '0;
        end else if (r_cnt == PhaseCntW'(T_RCD - 1)) begin
          w_state_d = StCol;
          w_cnt_d   = '0;
          w_ma_d    = MaW'(r_col);
        end
      end
      StCol: begin
        if (!w_uds || !w_lds) begin
          // Byte lanes are frozen here for the rest of the cycle
          w_state_d  = StHold;
          w_lane_u_d = !w_uds;
          w_lane_l_d = !w_lds;
        end else if (w_as) begin
          w_state_d = StPrecharge;
          w_cnt_d   = '0;
        end
      end
      StHold: begin
        if (w_as) begin
          w_state_d = StPrecharge;
          w_cnt_d   = '0;
        end
      end
      StPrecharge: begin
        if (r_cnt == PhaseCntW'(T_RP - 1)) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end
      end
      StRefCas: begin
        w_state_d = StRefRas;
        w_cnt_d   = '0;
      end
      StRefRas: begin
        if (r_cnt == PhaseCntW'(T_RFSH - 1)) begin
          w_state_d = StRefEnd;
          w_cnt_d   = '0;
        end
      end
      StRefEnd: begin
        w_state_d = StPrecharge;
        w_cnt_d   = '0;
      end
      default: w_state_d = StIdle;
    endcase

    w_ras_d   = !(w_state_d inside {StRow, StCol, StHold, StRefRas});
    w_casl_d  = !((w_state_d == StHold && w_lane_l_d) || (w_state_d inside {StRefCas, StRefRas}));
    w_casu_d  = !((w_state_d == StHold && w_lane_u_d) || (w_state_d inside {StRefCas, StRefRas}));
    w_we_d    = !((w_state_d inside {StCol, StHold}) && !w_rw_d);
    w_dtack_d = !(w_state_d == StHold);
    w_busy_d  = w_state_d inside {StRefCas, StRefRas};
  end

  assign bus.o_ma           = r_ma;
  assign bus.o_ras          = r_ras;
  assign bus.o_casl         = r_casl;
  assign bus.o_casu         = r_casu;
  assign bus.o_we           = r_we;
  assign bus.o_dtack_dram   = r_dtack;
  assign bus.o_refresh_busy = r_busy;

endmodule

// File: tb/tb_dram_controller.sv
// Directed bench for dram_controller with a scoreboard of expected CPU cycles.
module tb_dram_controller;
  import dram_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_controller_if bus ();

  dram_controller dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic [10:0] row;
    logic [10:0] col;
    logic        casl;
    logic        casu;
    logic        we;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   refresh_starts = 0;
  logic prev_busy = 1'b0;
  logic seen_casl_low, seen_casu_low, seen_dtack_low;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and record what the DRAM pins did
  task automatic step();
    @(negedge clk);
    if (bus.o_refresh_busy === 1'b1 && !prev_busy) refresh_starts++;
    prev_busy = (bus.o_refresh_busy === 1'b1);
    if (bus.o_casl === 1'b0) seen_casl_low = 1'b1;
    if (bus.o_casu === 1'b0) seen_casu_low = 1'b1;
    if (bus.o_dtack_dram === 1'b0) seen_dtack_low = 1'b1;
  endtask

  task automatic clear_seen();
    seen_casl_low  = 1'b0;
    seen_casu_low  = 1'b0;
    seen_dtack_low = 1'b0;
  endtask

  task automatic check_idle_pins(input string tag);
    check({tag, " RAS"}, bus.o_ras, 1);
    check({tag, " CASL"}, bus.o_casl, 1);
    check({tag, " CASU"}, bus.o_casu, 1);
    check({tag, " WE"}, bus.o_we, 1);
    check({tag, " DTACK"}, bus.o_dtack_dram, 1);
    check({tag, " MA"}, bus.o_ma, 0);
    check({tag, " BUSY"}, bus.o_refresh_busy, 0);
  endtask

  task automatic start_access(input logic [21:0] addr, input logic rw, input logic uds,
                              input logic lds);
    exp_t e;
    e.row  = addr[21:11];
    e.col  = addr[10:0];
    e.casl = lds;
    e.casu = uds;
    e.we   = rw;
    sb.push_back(e);
    bus.i_addr = addr;
    bus.i_rw   = rw;
    bus.i_dram = 1'b0;
    bus.i_as   = 1'b0;
    bus.i_uds  = uds;
    bus.i_lds  = lds;
  endtask

  task automatic wait_row(input string tag);
    int n = 0;
    while (!(bus.o_ras === 1'b0 && bus.o_refresh_busy === 1'b0) && n < 200) begin
      step();
      n++;
    end
    check({tag, " row timeout"}, (n < 200), 1);
    check({tag, " MA row"}, bus.o_ma, sb[0].row);
  endtask

  task automatic wait_dtack(input string tag);
    exp_t e;
    int   n = 0;
    while (bus.o_dtack_dram !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    check({tag, " dtack timeout"}, (n < 200), 1);
    e = sb.pop_front();
    check({tag, " MA col"}, bus.o_ma, e.col);
    check({tag, " CASL"}, bus.o_casl, e.casl);
    check({tag, " CASU"}, bus.o_casu, e.casu);
    check({tag, " WE"}, bus.o_we, e.we);
    check({tag, " RAS in hold"}, bus.o_ras, 0);
  endtask

  task automatic end_access(input string tag);
    int n = 0;
    int hi = 0;
    repeat (3) step();
    check({tag, " DTACK held"}, bus.o_dtack_dram, 0);
    bus.i_as   = 1'b1;
    bus.i_uds  = 1'b1;
    bus.i_lds  = 1'b1;
    bus.i_dram = 1'b1;
    while (bus.o_dtack_dram !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, " release timeout"}, (n < 20), 1);
    check({tag, " RAS with DTACK release"}, bus.o_ras, 1);
    check({tag, " WE released"}, bus.o_we, 1);
    check({tag, " CAS released"}, {bus.o_casu, bus.o_casl}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.o_ras === 1'b1) hi++;
    end
    check({tag, " precharge"}, hi, 3);
  endtask

  initial begin
    automatic int n = 0;
    automatic int rl = 0;
    automatic int r0 = 0;

    bus.i_as   = 1'b1;
    bus.i_uds  = 1'b1;
    bus.i_lds  = 1'b1;
    bus.i_dram = 1'b1;
    bus.i_rw   = 1'b1;
    bus.i_addr = '0;
    clear_seen();

    rst = 1'b1;
    repeat (3) step();
    check_idle_pins("reset");
    rst = 1'b0;
    repeat (2) step();

    // Word read
    clear_seen();
    start_access(22'h091A2B, 1'b1, 1'b0, 1'b0);
    wait_row("rd");
    wait_dtack("rd");
    end_access("rd");

    // Upper-byte write
    clear_seen();
    start_access(22'h1F0F0F, 1'b0, 1'b0, 1'b1);
    wait_row("wr");
    wait_dtack("wr");
    end_access("wr");
    check("wr CASL never low", seen_casl_low, 0);

    // Aborted cycle: AS released right after RAS falls, no data strobes
    clear_seen();
    bus.i_addr = 22'h000155;
    bus.i_rw   = 1'b1;
    bus.i_dram = 1'b0;
    bus.i_as   = 1'b0;
    n = 0;
    while (bus.o_ras !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    check("abort row timeout", (n < 50), 1);
    step();
    bus.i_as   = 1'b1;
    bus.i_dram = 1'b1;
    repeat (12) step();
    check("abort no CASL", seen_casl_low, 0);
    check("abort no CASU", seen_casu_low, 0);
    check("abort no DTACK", seen_dtack_low, 0);
    check("abort RAS high", bus.o_ras, 1);

    // Reset in the middle of HOLD
    clear_seen();
    start_access(22'h0ABCDE, 1'b1, 1'b0, 1'b0);
    wait_row("pre-rst");
    wait_dtack("pre-rst");
    rst = 1'b1;
    step();
    check_idle_pins("midhold reset");
    bus.i_as   = 1'b1;
    bus.i_uds  = 1'b1;
    bus.i_lds  = 1'b1;
    bus.i_dram = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    // Synced AS lands in IDLE on the same cycle the timer wraps
    repeat (597) step();
    clear_seen();
    r0 = refresh_starts;
    start_access(22'h3FFFFF, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (bus.o_refresh_busy !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("tie refresh first", (n < 20), 1);
    check("tie no DTACK before refresh", seen_dtack_low, 0);
    check("CBR CAS before RAS", {bus.o_ras, bus.o_casu, bus.o_casl}, 3'b100);
    rl = 0;
    step();
    while (bus.o_refresh_busy === 1'b1 && rl < 20) begin
      if (bus.o_ras === 1'b0) rl++;
      check("refresh WE high", bus.o_we, 1);
      step();
    end
    check("CBR RAS low cycles", rl, 4);
    wait_row("post-ref");
    wait_dtack("post-ref");
    end_access("post-ref");
    check("one refresh at tie", refresh_starts - r0, 1);

    // Hold AS across two timer wraps: exactly one refresh afterwards
    clear_seen();
    start_access(22'h1A5A5A, 1'b0, 1'b0, 1'b0);
    wait_row("long");
    wait_dtack("long");
    r0 = refresh_starts;
    repeat (1300) step();
    check("no refresh during hold", refresh_starts - r0, 0);
    end_access("long");
    repeat (60) step();
    check("single refresh after two wraps", refresh_starts - r0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
